// File: rtl/decode_stage_sb.sv
// decode_stage_sb: registered RV32I decode stage with valid/ready handshakes and RAW/WAW scoreboard.
// Optional macro DEC_WB_BYPASS_EN lets a same-cycle writeback unblock the hazard check.
module decode_stage_sb #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS = 2**REG_ADDR_WIDTH,
  parameter int STALL_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               instruction,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [6:0]                instruction_type,
  output logic [2:0]                funct3,
  output logic [6:0]                funct7,
  output logic [XLEN-1:0]           immediate,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic                      rs1_valid,
  output logic                      rs2_valid,
  output logic                      rd_valid,
  output logic                      illegal,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      flush,
  output logic                      decoder_stall,
  output logic [STALL_CNT_W-1:0]    stall_cycles
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_SYS = 7'b1110011;
  logic [6:0] op;
  logic [2:0] d_f3;
  logic [6:0] d_f7;
  logic signed [31:0] imm32;
  logic d_ill, d_r1v, d_r2v, d_rdv, hazard, accept;
  logic [REG_ADDR_WIDTH-1:0] d_rs1, d_rs2, d_rd;
  logic [NUM_REGS-1:0] sb, sb_eff, wb_mask, set_mask;
  assign op = instruction[6:0];
  always_comb begin
    d_ill = 1'b0;
    d_r1v = 1'b0;
    d_r2v = 1'b0;
    d_rdv = 1'b0;
    d_f3 = instruction[14:12];
    d_f7 = 7'd0;
    imm32 = '0;
    case (op)
      OP_R: begin d_r1v = 1'b1; d_r2v = 1'b1; d_rdv = 1'b1; d_f7 = instruction[31:25]; end
      OP_I, OP_LOAD, OP_JALR: begin
        d_r1v = 1'b1;
        d_rdv = 1'b1;
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      end
      OP_SYS: imm32 = {{20{instruction[31]}}, instruction[31:20]};
      OP_STORE: begin
        d_r1v = 1'b1;
        d_r2v = 1'b1;
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OP_BR: begin
        d_r1v = 1'b1;
        d_r2v = 1'b1;
        imm32 = {{20{instruction[31]}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin d_rdv = 1'b1; d_f3 = 3'd0; imm32 = {instruction[31:12], 12'd0}; end
      OP_JAL: begin
        d_rdv = 1'b1;
        d_f3 = 3'd0;
        imm32 = {{12{instruction[31]}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
      end
      default: begin d_ill = 1'b1; d_f3 = 3'd0; end
    endcase
  end
  assign d_rs1 = d_r1v ? REG_ADDR_WIDTH'(instruction[19:15]) : '0;
  assign d_rs2 = d_r2v ? REG_ADDR_WIDTH'(instruction[24:20]) : '0;
  assign d_rd  = d_rdv ? REG_ADDR_WIDTH'(instruction[11:7]) : '0;
  assign wb_mask = wb_valid ? NUM_REGS'(1) << wb_rd : '0;
`ifdef DEC_WB_BYPASS_EN
  assign sb_eff = sb & ~wb_mask;
`else
  assign sb_eff = sb;
`endif
  assign hazard = (d_r1v & sb_eff[d_rs1]) | (d_r2v & sb_eff[d_rs2]) | (d_rdv & sb_eff[d_rd]);
  assign in_ready = ~hazard & (~out_valid | out_ready) & ~flush;
  assign accept = in_valid & in_ready;
  assign decoder_stall = in_valid & ~in_ready;
  assign set_mask = (accept & d_rdv) ? NUM_REGS'(1) << d_rd : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      instruction_type <= '0;
      funct3 <= '0;
      funct7 <= '0;
      immediate <= '0;
      rs1 <= '0;
      rs2 <= '0;
      rd <= '0;
      rs1_valid <= 1'b0;
      rs2_valid <= 1'b0;
      rd_valid <= 1'b0;
      illegal <= 1'b0;
      sb <= '0;
      stall_cycles <= '0;
    end else begin
      if (in_valid & hazard & ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
      if (flush) begin
        out_valid <= 1'b0;
        sb <= '0;
      end else begin
        // set is OR-ed after the writeback clear so a same-index set wins; x0 never tracked
        sb <= ((sb & ~wb_mask) | set_mask) & ~NUM_REGS'(1);
        if (accept) begin
          out_valid <= 1'b1;
          instruction_type <= d_ill ? 7'd0 : op;
          funct3 <= d_f3;
          funct7 <= d_f7;
          immediate <= XLEN'(imm32);
          rs1 <= d_rs1;
          rs2 <= d_rs2;
          rd <= d_rd;
          rs1_valid <= d_r1v;
          rs2_valid <= d_r2v;
          rd_valid <= d_rdv;
          illegal <= d_ill;
        end else if (out_ready) out_valid <= 1'b0;
      end
    end
  end
endmodule
